// File: rtl/mac_pin_driver.sv
// Host-side pin driver for the MAC accelerator tile.
// Clears the MAC, streams (a,b) operand pairs onto its pins one per cycle,
// waits out the MAC pipeline, then reads the accumulator back byte-serially.
module mac_pin_driver #(
    parameter int unsigned LAT       = 2,
    parameter int unsigned RES_BYTES = 2,
    parameter int unsigned MAX_LEN   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [7:0]             op_a,
    input  logic [7:0]             op_b,
    input  logic                   op_last,
    output logic                   mac_rst_n,
    output logic                   mac_ena,
    output logic [7:0]             mac_ui_in,
    output logic [7:0]             mac_uio_in,
    input  logic [7:0]             mac_uo_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [8*RES_BYTES-1:0] res_data,
    output logic                   err
);

    localparam int unsigned RES_W  = 8 * RES_BYTES;
    localparam int unsigned LAT_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned PAIR_W = $clog2(MAX_LEN + 1);
    localparam int unsigned BYTE_W = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        FEED = 3'd2,
        WAIT = 3'd3,
        READ = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                hs_c;
    logic [LAT_W-1:0]    lat_cnt;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [PAIR_W-1:0]   pair_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an operand handshake only exists while feeding.
    always_comb begin
        state_nxt = state;
        hs_c      = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                state_nxt = FEED;
            end
            FEED: begin
                hs_c = op_valid & op_ready;
                if (hs_c && op_last) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (byte_cnt == BYTE_W'(RES_BYTES - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered pin outputs, aligned to the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ready   <= 1'b0;
            mac_rst_n  <= 1'b0;
            mac_ena    <= 1'b0;
            mac_ui_in  <= 8'h00;
            mac_uio_in <= 8'h00;
            res_valid  <= 1'b0;
        end else begin
            op_ready  <= (state_nxt == FEED);
            mac_rst_n <= (state_nxt != CLR);
            res_valid <= (state_nxt == DONE);
            mac_ena   <= hs_c;
            if (hs_c) begin
                mac_ui_in  <= op_a;
                mac_uio_in <= op_b;
            end
        end
    end

    // Pair counter per vector; saturates and flags the pair past MAX_LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt <= '0;
            err      <= 1'b0;
        end else if (state == CLR) begin
            pair_cnt <= '0;
        end else if (hs_c) begin
            if (pair_cnt == PAIR_W'(MAX_LEN)) begin
                err <= 1'b1;
            end else begin
                pair_cnt <= pair_cnt + PAIR_W'(1);
            end
        end
    end

    // Latency down-counter: holds LAT-1 while the last pair sits on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
        end else if (hs_c && op_last) begin
            lat_cnt <= LAT_W'(LAT - 1);
        end else if ((state == WAIT) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    // Byte-serial readback, LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            res_data <= RES_W'(0);
        end else if (state == READ) begin
            byte_cnt <= byte_cnt + BYTE_W'(1);
            for (int k = 0; k < RES_BYTES; k++) begin
                if (byte_cnt == BYTE_W'(k)) begin
                    res_data[8*k +: 8] <= mac_uo_out;
                end
            end
        end else begin
            byte_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mac_pin_driver.sv
// Directed bench for mac_pin_driver with a small two-stage MAC model on the pins.
module tb_mac_pin_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_last;
    logic        mac_rst_n;
    logic        mac_ena;
    logic [7:0]  mac_ui_in;
    logic [7:0]  mac_uio_in;
    logic [7:0]  mac_uo_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        err;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_pin_driver #(.LAT(2), .RES_BYTES(2), .MAX_LEN(255)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_last    (op_last),
        .mac_rst_n  (mac_rst_n),
        .mac_ena    (mac_ena),
        .mac_ui_in  (mac_ui_in),
        .mac_uio_in (mac_uio_in),
        .mac_uo_out (mac_uo_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .err        (err)
    );

    // MAC model: product stage then accumulate (2-cycle latency), then
    // the accumulator is presented one byte per cycle, LSB first.
    logic [15:0] m_prod;
    logic        m_pv;
    logic [31:0] m_acc;
    logic [1:0]  m_idx;

    always @(posedge clk) begin
        if (!mac_rst_n) begin
            m_prod <= 16'h0;
            m_pv   <= 1'b0;
            m_acc  <= 32'h0;
            m_idx  <= 2'd0;
        end else begin
            m_pv   <= mac_ena;
            m_prod <= 16'(mac_ui_in) * 16'(mac_uio_in);
            if (m_pv) m_acc <= m_acc + 32'(m_prod);
            if (mac_ena || m_pv) m_idx <= 2'd0;
            else if (m_idx != 2'd3) m_idx <= m_idx + 2'd1;
        end
    end

    assign mac_uo_out = m_acc[8*m_idx +: 8];

    // Pin activity counters, sampled on the falling edge.
    int  ena_cycles = 0;
    int  ena_rises  = 0;
    int  clr_cycles = 0;
    int  clr_pulses = 0;
    int  rv_rises   = 0;
    logic ena_q = 1'b0;
    logic mrst_q = 1'b1;
    logic rv_q = 1'b0;

    always @(negedge clk) begin
        if (mac_ena) ena_cycles++;
        if (mac_ena && !ena_q) ena_rises++;
        if (rst_n && !mac_rst_n) clr_cycles++;
        if (rst_n && !mac_rst_n && mrst_q) clr_pulses++;
        if (res_valid && !rv_q) rv_rises++;
        ena_q  = mac_ena;
        mrst_q = mac_rst_n;
        rv_q   = res_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one pair, wait for its handshake, then idle op_valid for gap cycles.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, input int gap);
        int budget;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_last  = last;
        budget   = 0;
        while (!op_ready && budget < 20) begin
            tick();
            budget++;
        end
        n_asrt++;
        assert (op_ready === 1'b1) else begin
            n_fail++;
            $error("FAIL handshake: observed op_ready=%b expected=1", op_ready);
        end
        tick();
        op_valid = 1'b0;
        op_last  = 1'b0;
        repeat (gap) tick();
    endtask

    // Wait (bounded) for res_valid and return the data it carries.
    task automatic wait_res(output logic [15:0] data);
        int budget;
        budget = 0;
        while (!res_valid && budget < 60) begin
            tick();
            budget++;
        end
        n_asrt++;
        assert (res_valid === 1'b1) else begin
            n_fail++;
            $error("FAIL res_wait: observed res_valid=%b expected=1", res_valid);
        end
        data = res_data;
    endtask

    // Accept the pending result and confirm res_valid drops the next cycle.
    task automatic accept(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk(tag, 32'(res_valid), 32'd0);
    endtask

    logic [15:0] r;
    int s_ena, s_rise, s_clrc, s_clrp, s_rv;

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_a      = 8'h00;
        op_b      = 8'h00;
        op_last   = 1'b0;
        res_ready = 1'b0;

        // Reset values.
        repeat (3) tick();
        chk("rst_op_ready",  32'(op_ready),   32'd0);
        chk("rst_mac_rst_n", 32'(mac_rst_n),  32'd0);
        chk("rst_mac_ena",   32'(mac_ena),    32'd0);
        chk("rst_ui",        32'(mac_ui_in),  32'd0);
        chk("rst_uio",       32'(mac_uio_in), 32'd0);
        chk("rst_res_valid", 32'(res_valid),  32'd0);
        chk("rst_res_data",  32'(res_data),   32'd0);
        chk("rst_err",       32'(err),        32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_mac_rst_n", 32'(mac_rst_n), 32'd1);
        chk("idle_op_ready",  32'(op_ready),  32'd0);
        chk("idle_mac_ena",   32'(mac_ena),   32'd0);

        // Vector (3,4),(5,6),(7,8): 12+30+56 = 98.
        s_ena = ena_cycles; s_rise = ena_rises; s_clrc = clr_cycles; s_clrp = clr_pulses;
        send(8'd3, 8'd4, 1'b0, 0);
        send(8'd5, 8'd6, 1'b0, 0);
        send(8'd7, 8'd8, 1'b1, 0);
        chk("v1_op_ready_wait", 32'(op_ready),   32'd0);
        chk("v1_pin_a_hold",    32'(mac_ui_in),  32'd7);
        chk("v1_pin_b_hold",    32'(mac_uio_in), 32'd8);
        wait_res(r);
        chk("v1_res_data",   32'(r),                  32'h0062);
        chk("v1_clr_pulses", 32'(clr_pulses - s_clrp), 32'd1);
        chk("v1_clr_cycles", 32'(clr_cycles - s_clrc), 32'd1);
        chk("v1_ena_cycles", 32'(ena_cycles - s_ena),  32'd3);
        chk("v1_ena_rises",  32'(ena_rises - s_rise),  32'd1);
        accept("v1_release");

        // Single pair (255,255): 65025 = 0xFE01, held while res_ready low.
        tick();
        send(8'd255, 8'd255, 1'b1, 0);
        wait_res(r);
        chk("v2_res_data", 32'(r), 32'hFE01);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("v2_hold_valid", 32'(res_valid), 32'd1);
            chk("v2_hold_data",  32'(res_data),  32'hFE01);
        end
        accept("v2_release");

        // Bubbles between pairs: same sum, three separate mac_ena pulses.
        tick();
        s_ena = ena_cycles; s_rise = ena_rises;
        send(8'd3, 8'd4, 1'b0, 1);
        send(8'd5, 8'd6, 1'b0, 1);
        send(8'd7, 8'd8, 1'b1, 0);
        wait_res(r);
        chk("v3_res_data",   32'(r),                  32'h0062);
        chk("v3_ena_cycles", 32'(ena_cycles - s_ena), 32'd3);
        chk("v3_ena_rises",  32'(ena_rises - s_rise), 32'd3);
        accept("v3_release");

        // Back-to-back vectors: (1,2),(3,4) = 14 then (2,5) = 10.
        s_clrp = clr_pulses;
        send(8'd1, 8'd2, 1'b0, 0);
        send(8'd3, 8'd4, 1'b1, 0);
        wait_res(r);
        chk("v4a_res_data", 32'(r), 32'h000E);
        accept("v4a_release");
        send(8'd2, 8'd5, 1'b1, 0);
        wait_res(r);
        chk("v4b_res_data",   32'(r),                  32'h000A);
        chk("v4_clr_pulses",  32'(clr_pulses - s_clrp), 32'd2);
        accept("v4b_release");

        // 256 pairs of (1,1): err rises on pair 256; result 256 still returned.
        tick();
        for (int i = 0; i < 255; i++) send(8'd1, 8'd1, 1'b0, 0);
        chk("v5_err_at_255", 32'(err), 32'd0);
        send(8'd1, 8'd1, 1'b1, 0);
        chk("v5_err_at_256", 32'(err), 32'd1);
        wait_res(r);
        chk("v5_res_data", 32'(r), 32'h0100);
        accept("v5_release");
        repeat (3) tick();
        chk("v5_err_sticky", 32'(err), 32'd1);

        // Reset while waiting on the MAC: no result, then a clean vector.
        send(8'd1, 8'd1, 1'b0, 0);
        send(8'd1, 8'd1, 1'b1, 0);
        rst_n = 1'b0;
        #1;
        chk("v6_rst_res_valid", 32'(res_valid), 32'd0);
        chk("v6_rst_op_ready",  32'(op_ready),  32'd0);
        chk("v6_rst_mac_rst_n", 32'(mac_rst_n), 32'd0);
        chk("v6_rst_mac_ena",   32'(mac_ena),   32'd0);
        chk("v6_rst_err",       32'(err),       32'd0);
        tick();
        rst_n = 1'b1;
        s_rv = rv_rises;
        repeat (10) tick();
        chk("v6_no_res_valid", 32'(rv_rises - s_rv), 32'd0);
        send(8'd2, 8'd3, 1'b1, 0);
        wait_res(r);
        chk("v6_res_data", 32'(r), 32'h0006);
        accept("v6_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
